// File: rtl/rgba_sprite_writer_if.sv
// Command, image-reader and framebuffer-write signals of rgba_sprite_writer.
// The master side is the scene sequencer together with the image memory read data.
interface rgba_sprite_writer_if;
  logic        start;
  logic [9:0]  dst_x;
  logic [8:0]  dst_y;
  logic [9:0]  spr_w;
  logic [8:0]  spr_h;
  logic        busy;
  logic        done;
  logic [18:0] src_addr;
  logic [15:0] src_rgba;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [11:0] fb_data;

  modport master (
    output start, dst_x, dst_y, spr_w, spr_h, src_rgba,
    input  busy, done, src_addr, fb_we, fb_addr, fb_data
  );

  modport slave (
    input  start, dst_x, dst_y, spr_w, spr_h, src_rgba,
    output busy, done, src_addr, fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/rgba_sprite_writer.sv
// Blits an RGBA4444 sprite into the RGB444 framebuffer write port, skipping transparent pixels.
// Optional macro FB_CLIP_EN suppresses writes that fall outside FB_WIDTH x FB_HEIGHT.
module rgba_sprite_writer #(
  parameter int unsigned FB_WIDTH  = 640,
  parameter int unsigned FB_HEIGHT = 480,
  parameter int unsigned ALPHA_MIN = 8
) (
  input logic                 clk,
  input logic                 rst,
  rgba_sprite_writer_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [9:0]  dst_x_q, dst_x_d;
  logic [8:0]  dst_y_q, dst_y_d;
  logic [9:0]  spr_w_q, spr_w_d;
  logic [8:0]  spr_h_q, spr_h_d;
  logic [9:0]  col_q, col_d;
  logic [8:0]  row_q, row_d;
  logic [18:0] src_addr_q, src_addr_d;
  logic        drain_q, drain_d;
  logic        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [10:0] s1_col_q, s1_col_d, s2_col_q, s2_col_d;
  logic [9:0]  s1_row_q, s1_row_d, s2_row_q, s2_row_d;
  logic [18:0] fb_addr_q, fb_addr_d;
  logic [11:0] fb_data_q, fb_data_d;
  logic        fb_we_c;
  logic        in_bounds;
  logic        last_pix;

  assign last_pix = (col_q == spr_w_q - 10'd1) && (row_q == spr_h_q - 9'd1);

  always_comb begin
    state_d    = state_q;
    dst_x_d    = dst_x_q;
    dst_y_d    = dst_y_q;
    spr_w_d    = spr_w_q;
    spr_h_d    = spr_h_q;
    col_d      = col_q;
    row_d      = row_q;
    src_addr_d = src_addr_q;
    drain_d    = drain_q;
    // Stage 1 captures the fb coordinates of the pixel being issued this cycle.
    s1_valid_d = 1'b0;
    s1_col_d   = {1'b0, dst_x_q} + {1'b0, col_q};
    s1_row_d   = {1'b0, dst_y_q} + {1'b0, row_q};
    s2_valid_d = s1_valid_q;
    s2_col_d   = s1_col_q;
    s2_row_d   = s1_row_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dst_x_d = bus.dst_x;
          dst_y_d = bus.dst_y;
          spr_w_d = bus.spr_w;
          spr_h_d = bus.spr_h;
          col_d   = '0;
          row_d   = '0;
          if (bus.spr_w == 10'd0 || bus.spr_h == 9'd0) begin
            state_d = S_FINISH;
          end else begin
            state_d    = S_ISSUE;
            src_addr_d = '0;
          end
        end
      end
      S_ISSUE: begin
        s1_valid_d = 1'b1;
        if (last_pix) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          // Raster order makes row*spr_w+col a plain running count.
          src_addr_d = src_addr_q + 19'd1;
          if (col_q == spr_w_q - 10'd1) begin
            col_d = '0;
            row_d = row_q + 9'd1;
          end else begin
            col_d = col_q + 10'd1;
          end
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_FINISH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
`ifdef FB_CLIP_EN
    in_bounds = ({21'd0, s2_col_q} < FB_WIDTH) && ({22'd0, s2_row_q} < FB_HEIGHT);
`else
    in_bounds = 1'b1;
`endif
    // Read data arrives this cycle, so the write decision is combinational on src_rgba.
    fb_we_c   = s2_valid_q && ({28'd0, bus.src_rgba[3:0]} >= ALPHA_MIN) && in_bounds;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    if (fb_we_c) begin
      fb_addr_d = 19'(s2_row_q) * 19'(FB_WIDTH) + 19'(s2_col_q);
      fb_data_d = bus.src_rgba[15:4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dst_x_q    <= '0;
      dst_y_q    <= '0;
      spr_w_q    <= '0;
      spr_h_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      src_addr_q <= '0;
      drain_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_col_q   <= '0;
      s2_row_q   <= '0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      dst_x_q    <= dst_x_d;
      dst_y_q    <= dst_y_d;
      spr_w_q    <= spr_w_d;
      spr_h_q    <= spr_h_d;
      col_q      <= col_d;
      row_q      <= row_d;
      src_addr_q <= src_addr_d;
      drain_q    <= drain_d;
      s1_valid_q <= s1_valid_d;
      s1_col_q   <= s1_col_d;
      s1_row_q   <= s1_row_d;
      s2_valid_q <= s2_valid_d;
      s2_col_q   <= s2_col_d;
      s2_row_q   <= s2_row_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
    end
  end

  assign bus.busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign bus.done     = (state_q == S_FINISH);
  assign bus.src_addr = src_addr_q;
  assign bus.fb_we    = fb_we_c;
  assign bus.fb_addr  = fb_addr_d;
  assign bus.fb_data  = fb_data_d;
endmodule

// File: tb/tb_rgba_sprite_writer.sv
// Self-checking bench for rgba_sprite_writer: directed and random blits against a pixel-list model.
// Define FB_CLIP_EN for both bench and RTL to check the clipping build.
module tb_rgba_sprite_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  rgba_sprite_writer_if bus();

  rgba_sprite_writer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Image memory: registered BRAM read plus output register, two cycles of latency.
  logic [15:0] src_mem [0:255];
  logic [15:0] rd1;
  always @(posedge clk) begin
    rd1          <= src_mem[bus.src_addr[7:0]];
    bus.src_rgba <= rd1;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int last_addr = 0;
  int last_data = 0;

  task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, c, got, exp);
    end
  endtask

  // Expected framebuffer effect of sprite pixel k, derived from geometry alone.
  task automatic model_pix(input int dx, input int dy, input int w, input int k,
                           output bit we, output int addr, output int data);
    int col, row;
    col  = dx + k % w;
    row  = dy + k / w;
    we   = (src_mem[k][3:0] >= 4'd8);
`ifdef FB_CLIP_EN
    if (col >= 640 || row >= 480) we = 1'b0;
`endif
    addr = (row * 640 + col) % (1 << 19);
    data = int'(src_mem[k][15:4]);
  endtask

  task automatic run_blit(input int dx, input int dy, input int w, input int h, input bit repulse);
    int n, last, k, ea, ed;
    bit ew;
    n    = w * h;
    last = (n == 0) ? 1 : n + 3;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dst_x = 10'(dx);
    bus.dst_y = 9'(dy);
    bus.spr_w = 10'(w);
    bus.spr_h = 9'(h);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      // A zero-size blit keeps start high into FINISH, where it must be ignored.
      if (n != 0 && c == 1) bus.start = 1'b0;
      if (repulse && c == 2) begin
        bus.start = 1'b1;
        bus.dst_x = 10'(dx + 7);
        bus.dst_y = 9'(dy + 3);
        bus.spr_w = 10'(w + 1);
      end
      if (repulse && c == 3) bus.start = 1'b0;
      chk("busy", c, 32'(bus.busy), 32'((n != 0) && (c <= n + 2)));
      chk("done", c, 32'(bus.done), 32'(c == last));
      if (c <= n) chk("src_addr", c, 32'(bus.src_addr), 32'(c - 1));
      k  = c - 3;
      ew = 1'b0;
      if (k >= 0 && k < n) model_pix(dx, dy, w, k, ew, ea, ed);
      chk("fb_we", c, 32'(bus.fb_we), 32'(ew));
      if (ew) begin
        last_addr = ea;
        last_data = ed;
      end
      chk("fb_addr", c, 32'(bus.fb_addr), 32'(last_addr));
      chk("fb_data", c, 32'(bus.fb_data), 32'(last_data));
    end
    if (n == 0) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_finish", 2, 32'(bus.busy), 32'd0);
      chk("done_after_finish", 2, 32'(bus.done), 32'd0);
      chk("fb_we_zero", 2, 32'(bus.fb_we), 32'd0);
    end
    $display("blit dst=(%0d,%0d) size=%0dx%0d repulse=%0d checked through cycle %0d",
             dx, dy, w, h, repulse, last);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dst_x = '0;
    bus.dst_y = '0;
    bus.spr_w = '0;
    bus.spr_h = '0;
    for (int i = 0; i < 256; i++) src_mem[i] = 16'h000F;
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, 32'(bus.busy), 32'd0);
    chk("rst_done", 0, 32'(bus.done), 32'd0);
    chk("rst_fb_we", 0, 32'(bus.fb_we), 32'd0);
    chk("rst_src_addr", 0, 32'(bus.src_addr), 32'd0);
    chk("rst_fb_addr", 0, 32'(bus.fb_addr), 32'd0);
    chk("rst_fb_data", 0, 32'(bus.fb_data), 32'd0);
    rst = 1'b0;

    // 2x2 opaque ramp at (10,5): writes 3210, 3211, 3850, 3851.
    for (int i = 0; i < 4; i++) src_mem[i] = {4'(i + 1), 4'(i + 2), 4'(i + 3), 4'hF};
    run_blit(10, 5, 2, 2, 1'b0);

    // Alpha threshold: only the first of {F, 0, 7} is written.
    src_mem[0] = 16'hABCF;
    src_mem[1] = 16'h1230;
    src_mem[2] = 16'h4567;
    run_blit(20, 30, 3, 1, 1'b0);

    run_blit(5, 5, 0, 4, 1'b0);

    for (int i = 0; i < 8; i++) src_mem[i] = {12'(i * 291 + 7), 4'(8 + i)};
    run_blit(50, 60, 4, 2, 1'b1);

    for (int i = 0; i < 4; i++) src_mem[i] = {12'(i + 16'h0A0), 4'hF};
    run_blit(638, 0, 4, 1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) src_mem[i] = 16'($urandom);
      run_blit(int'($urandom_range(639, 0)), int'($urandom_range(479, 0)),
               int'($urandom_range(6, 1)), int'($urandom_range(4, 1)), 1'b0);
    end

    // Reset in the middle of an 8x8 blit, then a normal 1x1 blit.
    for (int i = 0; i < 64; i++) src_mem[i] = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dst_x = 10'd100;
    bus.dst_y = 9'd100;
    bus.spr_w = 10'd8;
    bus.spr_h = 9'd8;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_fb_we", 0, 32'(bus.fb_we), 32'd0);
    chk("midrst_busy", 0, 32'(bus.busy), 32'd0);
    chk("midrst_done", 0, 32'(bus.done), 32'd0);
    last_addr = 0;
    last_data = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("postrst_fb_we", c, 32'(bus.fb_we), 32'd0);
      chk("postrst_busy", c, 32'(bus.busy), 32'd0);
      chk("postrst_done", c, 32'(bus.done), 32'd0);
    end
    src_mem[0] = 16'h9A5C;
    run_blit(3, 2, 1, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rgba_sprite_writer.md
Name: rgba_sprite_writer

Overview:
- Blits a rectangular RGBA4444 sprite from a source image memory into the RGB444 framebuffer BRAM write port.
- Issues linear source addresses and consumes pixels with the fixed 2-cycle read latency of the image reader path (BRAM + output register).
- Writes opaque pixels to framebuffer address y*FB_WIDTH+x and skips transparent ones.
- Sits between the game-scene sequencer (command side) and the framebuffer BRAM port A (write side).

Parameters:
FB_WIDTH, 640, framebuffer width in pixels; address stride.
FB_HEIGHT, 480, framebuffer height in pixels; used only by clipping.
ALPHA_MIN, 8, a source pixel is written iff A[3:0] >= ALPHA_MIN.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle blit request; sampled only in IDLE
dst_x  in  10  destination left column; latched at start
dst_y  in  9  destination top row; latched at start
spr_w  in  10  sprite width in pixels; latched at start
spr_h  in  9  sprite height in pixels; latched at start
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at blit completion
src_addr  out  19  source pixel address: row*spr_w+col
src_rgba  in  16  source pixel R[15:12] G[11:8] B[7:4] A[3:0], valid 2 cycles after src_addr
fb_we  out  1  framebuffer write enable
fb_addr  out  19  framebuffer write address
fb_data  out  12  RGB444 write data {R,G,B}

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, fb_we = 0; src_addr, fb_addr, fb_data = 0; pipeline valids cleared. No write is issued after reset assertion.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: start=1 latches dst_x, dst_y, spr_w, spr_h and zeroes col/row. Goes to FINISH if spr_w==0 or spr_h==0 (no writes, no source reads); otherwise goes to ISSUE.
- ISSUE: presents one src_addr per cycle in raster order (col fastest).
  - Pixel k is issued in cycle k+1 after the start edge.
  - After the last pixel (col=spr_w-1, row=spr_h-1), goes to DRAIN.
- Pipeline: a 2-stage shift of {valid, fb column, fb row} runs alongside the BRAM latency.
  - For pixel k, src_rgba is consumed in cycle k+3.
  - In that cycle: fb_we = (A >= ALPHA_MIN), fb_addr = (dst_y+row)*FB_WIDTH + (dst_x+col) computed in 19 bits, fb_data = src_rgba[15:4].
- DRAIN: lasts 2 cycles to retire the in-flight pixels, then goes to FINISH.
- FINISH: done=1 and busy=0 for one cycle, then IDLE.
- Total: an N=w*h blit with N>0 takes N+3 cycles from the start edge to the done cycle. A zero-size blit gives done in cycle 1.
- busy=1 in ISSUE and DRAIN; busy=0 in IDLE and FINISH.
- start while busy or in FINISH: ignored, not queued. Input changes after the latch are ignored.
- When fb_we=0, fb_addr and fb_data hold their previous values.
- Arithmetic: all address math is unsigned; products are truncated to 19 bits. Source address = row*spr_w + col, with a running base (+spr_w per row), so no multiplier is needed on the source side.

Optional Feature:
FB_CLIP_EN defined:
- A pixel whose fb column >= FB_WIDTH or fb row >= FB_HEIGHT is suppressed (fb_we=0).
- Source reads and cycle count are unchanged.
FB_CLIP_EN undefined:
- No bounds check; out-of-range coordinates produce a wrapped 19-bit address and the write is still issued.
- Keeping sprites on-screen is the caller's responsibility.

Test Plan:
- 2x2 opaque sprite (A=F, R/G/B = 1,2,3 … 4-pixel ramp), dst=(10,5), FB_WIDTH=640 -> writes to addresses 3210, 3211, 3850, 3851 in cycles 3, 4, 5, 6; done in cycle 7; src_addr 0..3 in cycles 1..4.
- 3x1 sprite with alphas {F, 0, 7}, ALPHA_MIN=8 -> single write at pixel 0. fb_we is low in the pixel 1 and pixel 2 slots; done still in cycle 6.
- spr_w=0, spr_h=4 -> no src reads, no writes; done pulse in cycle 1; busy never asserted.
- start re-pulsed during ISSUE with different dst -> ignored; original addresses only. A start pulse in the cycle after done is accepted.
- FB_CLIP_EN: 4x1 sprite at dst=(638,0) -> writes only addresses 638 and 639; done at cycle 7. Without the macro -> 4 writes, to 638..641.
- rst asserted during ISSUE of an 8x8 blit -> fb_we, busy, done = 0 immediately. After release, no write until a new start; the next 1x1 blit completes normally.
